fetch_align_buffer: RTL and testbench
=====================================

Name: fetch_align_buffer

Overview:
- IF-stage front end for the compressed-ISA pipeline.
- Drives the I-cache word address, takes 32-bit cache words, byte-swaps them into instruction order, and splits them into 16-bit parcels in a small parcel queue.
- Presents one aligned instruction per cycle to IF/ID, with its PC and an RVC flag. An instruction may be one 16-bit parcel or two parcels that straddle a word boundary.
- Replaces the upper16/flag straddle bookkeeping in the PC logic. The downstream decompressor consumes id_inst when id_compressed=1.

Parameters:
- PARCELS, 6, queue depth in 16-bit parcels; even, >=4.
- RESET_PC, 32'h0000_0000, PC after reset; bit0 must be 0.

Ports:
- clk  in  1  clock
- proc_reset  in  1  synchronous active-high reset
- icache_ren  out  1  read request; high when free parcel slots >=2 and redirect=0
- icache_addr  out  30  word address of the next fetch (byte address [31:2])
- icache_rdata  in  32  cache data in memory byte order; valid when icache_stall=0
- icache_stall  in  1  cache miss/busy; no word accepted this cycle
- redirect  in  1  branch/jump taken from ID (pc_sel)
- redirect_pc  in  32  target PC; bit0 ignored
- id_ready  in  1  IF/ID may load; equals !stall of the pipeline
- id_valid  out  1  id_inst/id_pc are a complete instruction
- id_inst  out  32  raw instruction in instruction order; upper 16 bits zero when compressed
- id_pc  out  32  PC of id_inst
- id_compressed  out  1  id_inst[1:0] != 2'b11

Behaviour:
- Byte swap: w = {rdata[7:0], rdata[15:8], rdata[23:16], rdata[31:24]}.
  - Lower parcel w[15:0] is at byte address +0; upper parcel w[31:16] is at +2.
- Word accept condition: icache_ren & !icache_stall & !redirect.
  - On accept, icache_addr increments by 1.
  - Parcels are pushed in address order.
  - Free-slot check uses the occupancy count before any same-cycle pop.
- Alignment FSM, two states:
  - ALIGNED: accept pushes 2 parcels.
  - SKIP_LO: accept pushes only w[31:16], then goes to ALIGNED.
  - redirect: next state is SKIP_LO if redirect_pc[1]=1, else ALIGNED.
- Output selection from the head parcel h:
  - h[1:0]!=11 and count>=1: id_valid=1, id_compressed=1, id_inst={16'h0,h}.
  - h[1:0]==11 and count>=2: id_valid=1, id_compressed=0, id_inst={h_next,h}.
  - h[1:0]==11 and count==1: id_valid=0. The straddling instruction waits for the next word.
  - id_valid=0 forces id_inst=0 and id_compressed=0.
- Pop condition: id_valid & id_ready & !redirect.
  - Pops 1 parcel (compressed) or 2 parcels.
  - id_pc advances by 2 or 4 and wraps modulo 2^32.
- Push and pop in the same cycle are legal; count_next = count + pushed - popped.
- Count is never >PARCELS and never <0. Asserted in simulation.
- Redirect has priority over push and pop in the same cycle:
  - queue flushed (count=0, head=tail=0);
  - icache_addr <= redirect_pc[31:2];
  - id_pc <= {redirect_pc[31:1],1'b0};
  - id_valid forced 0 in the redirect cycle.
- A redirect during icache_stall takes effect immediately. The stalled word is never pushed, because icache_addr changes and the cache re-requests.
- Latency:
  - After reset or redirect, the first instruction is visible the cycle after the first accepted word (registered queue).
  - A straddling 32-bit instruction appears the cycle after the second word is accepted.
- Reset values: count=0, head=tail=0, state=ALIGNED, icache_addr=RESET_PC[31:2], id_pc=RESET_PC, id_valid=0, id_inst=0, id_compressed=0, icache_ren=1.
- proc_reset mid-operation discards all queued parcels and any pending stall in the next cycle.

Decomposition:
- Shared package (if_pkg):
  - PARCEL_W=16;
  - OPC_FULL=2'b11;
  - state encodings FA_ALIGNED / FA_SKIP_LO;
  - byte-swap function shared with the D-side data path.
- Sub-module fetch_parcel_fifo:
  - circular parcel store, depth PARCELS;
  - push 0/1/2, pop 0/1/2;
  - flush input;
  - outputs head, head_next, count.
- Top level holds the FSM, address counter, PC register and output selection.

Test Plan:
- Reset, cache word at addr 0 = rdata 32'h9300_5000 (w=0x00500093), no stall -> cycle after accept: id_valid=1, id_inst=0x00500093, id_pc=0, id_compressed=0; next id_pc=4.
- Straddle: w@0=0x00934505, w@4=0xFFFF0050 -> id_inst=0x00004505 pc=0 compressed=1; then 0x00500093 pc=2 only after word@4 accepted; id_valid=0 between if word@4 stalls 5 cycles.
- Redirect to 0x0000_0102 while queue holds 4 parcels -> same cycle id_valid=0; icache_addr=0x40; first word pushes only upper parcel; id_pc=0x102.
- id_ready=0 for 10 cycles with a full stream -> count saturates at PARCELS; icache_ren=0 once free<2; no parcel lost or duplicated on release (PC sequence continuous).
- Push and pop same cycle with count=PARCELS-2 and compressed head -> accept permitted; count_next=PARCELS-1.
- proc_reset asserted mid-straddle with icache_stall=1 -> next cycle: count=0, id_valid=0, icache_addr=RESET_PC[31:2], state ALIGNED.

Source files
------------

// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared IF-stage constants, alignment state encodings and byte-swap helper
// No ports: imported by fetch_parcel_fifo and fetch_align_buffer.
package if_pkg;

  localparam int         PARCEL_W = 16;
  localparam logic [1:0] OPC_FULL = 2'b11;

  typedef enum logic {
    FA_ALIGNED = 1'b0,
    FA_SKIP_LO = 1'b1
  } fa_state_e;

  // Memory byte order -> instruction order; the D-side data path uses the same swap.
  function automatic logic [31:0] byte_swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/fetch_parcel_fifo.sv
// rtl/fetch_parcel_fifo.sv - circular store of 16-bit instruction parcels, 0/1/2 push and pop per cycle
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               drop all parcels (redirect)
//   push_n, push_lo/hi  number of parcels to write this cycle and their data, lo first
//   pop_n               number of parcels to retire from the head this cycle
//   head, head_next     oldest parcel and the one after it
//   count               parcels currently held
module fetch_parcel_fifo
  import if_pkg::*;
#(
  parameter int PARCELS = 6,
  localparam int PW = $clog2(PARCELS),
  localparam int CW = $clog2(PARCELS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [1:0]          push_n,
  input  logic [PARCEL_W-1:0] push_lo,
  input  logic [PARCEL_W-1:0] push_hi,
  input  logic [1:0]          pop_n,
  output logic [PARCEL_W-1:0] head,
  output logic [PARCEL_W-1:0] head_next,
  output logic [CW-1:0]       count
);

  logic [PARCEL_W-1:0] store [PARCELS];
  logic [PW-1:0]       head_ptr;
  logic [PW-1:0]       tail_ptr;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
    logic [PW:0] s;
    s = {1'b0, p} + {{(PW-1){1'b0}}, n};
    if (s >= (PW+1)'(PARCELS)) s = s - (PW+1)'(PARCELS);
    return s[PW-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      tail_ptr <= ptr_add(tail_ptr, push_n);
      head_ptr <= ptr_add(head_ptr, pop_n);
      count    <= count + CW'(push_n) - CW'(pop_n);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (push_n != 2'd0) store[tail_ptr] <= push_lo;
      if (push_n == 2'd2) store[ptr_add(tail_ptr, 2'd1)] <= push_hi;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count <= CW'(PARCELS));
      assert (CW'(pop_n) <= count);
    end
  end

  assign head      = store[head_ptr];
  assign head_next = store[ptr_add(head_ptr, 2'd1)];

endmodule

// File: rtl/fetch_align_buffer.sv
// rtl/fetch_align_buffer.sv - IF front end: I-cache fetch, parcel alignment, one instruction per cycle to IF/ID
// Ports:
//   clk, proc_reset                  clock, synchronous active-high reset
//   icache_ren/addr/rdata/stall      word fetch interface (word address, memory byte order data)
//   redirect, redirect_pc            taken branch/jump from ID; flushes and restarts fetch
//   id_ready                         IF/ID can load this cycle
//   id_valid/inst/pc/compressed      aligned instruction, its PC and RVC flag
module fetch_align_buffer
  import if_pkg::*;
#(
  parameter int          PARCELS  = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        proc_reset,
  output logic        icache_ren,
  output logic [29:0] icache_addr,
  input  logic [31:0] icache_rdata,
  input  logic        icache_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        id_compressed
);

  localparam int CW = $clog2(PARCELS + 1);

  fa_state_e           state;
  logic [31:0]         w;
  logic [CW-1:0]       count;
  logic [PARCEL_W-1:0] head;
  logic [PARCEL_W-1:0] head_next;
  logic                full_head;
  logic                accept;
  logic                pop;
  logic [1:0]          push_n;
  logic [1:0]          pop_n;
  logic [PARCEL_W-1:0] push_lo;

  assign w = byte_swap(icache_rdata);

  always_comb begin
    full_head  = (head[1:0] == OPC_FULL);
    // Free-slot test uses the pre-pop count: a word is only requested when both parcels fit.
    icache_ren = !redirect && (count <= CW'(PARCELS - 2));
    accept     = icache_ren && !icache_stall;
    push_n     = 2'd0;
    if (accept) push_n = (state == FA_SKIP_LO) ? 2'd1 : 2'd2;
    // After a redirect into the upper half of a word, the lower parcel is discarded.
    push_lo    = (state == FA_SKIP_LO) ? w[31:16] : w[15:0];

    // A 32-bit head with only one parcel present is waiting for the next word.
    id_valid      = !redirect && (full_head ? (count >= CW'(2)) : (count != '0));
    id_compressed = id_valid && !full_head;
    id_inst       = 32'h0;
    if (id_valid) id_inst = full_head ? {head_next, head} : {16'h0, head};

    pop   = id_valid && id_ready;
    pop_n = 2'd0;
    if (pop) pop_n = full_head ? 2'd2 : 2'd1;
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state       <= FA_ALIGNED;
      icache_addr <= RESET_PC[31:2];
      id_pc       <= RESET_PC;
    end else if (redirect) begin
      state       <= redirect_pc[1] ? FA_SKIP_LO : FA_ALIGNED;
      icache_addr <= redirect_pc[31:2];
      id_pc       <= redirect_pc & ~32'h1;
    end else begin
      if (accept) begin
        state       <= FA_ALIGNED;
        icache_addr <= icache_addr + 30'd1;
      end
      if (pop) id_pc <= id_pc + (full_head ? 32'd4 : 32'd2);
    end
  end

  fetch_parcel_fifo #(.PARCELS(PARCELS)) u_fifo (
    .clk       (clk),
    .rst       (proc_reset),
    .flush     (redirect),
    .push_n    (push_n),
    .push_lo   (push_lo),
    .push_hi   (w[31:16]),
    .pop_n     (pop_n),
    .head      (head),
    .head_next (head_next),
    .count     (count)
  );

endmodule

// File: tb/tb_fetch_align_buffer.sv
// tb/tb_fetch_align_buffer.sv - scoreboard bench for fetch_align_buffer
module tb_fetch_align_buffer;

  logic        clk = 1'b0;
  logic        proc_reset;
  logic        icache_ren;
  logic [29:0] icache_addr;
  logic [31:0] icache_rdata;
  logic        icache_stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_compressed;

  always #5 clk = ~clk;

  // Cache model: words outside mem_ok stall forever, so no unplanned instruction can complete.
  logic [31:0]  mem [256];
  logic [255:0] mem_ok;
  logic [29:0]  stall_addr;
  int           stall_until;
  int           cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  assign icache_rdata = mem[icache_addr[7:0]];
  assign icache_stall = !mem_ok[icache_addr[7:0]] || (icache_addr == stall_addr && cyc < stall_until);

  fetch_align_buffer dut (
    .clk           (clk),
    .proc_reset    (proc_reset),
    .icache_ren    (icache_ren),
    .icache_addr   (icache_addr),
    .icache_rdata  (icache_rdata),
    .icache_stall  (icache_stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .id_ready      (id_ready),
    .id_valid      (id_valid),
    .id_inst       (id_inst),
    .id_pc         (id_pc),
    .id_compressed (id_compressed)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        c;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] bsw(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic expect_inst(input logic [31:0] i, input logic [31:0] p, input logic c);
    exp_t e;
    e.inst = i;
    e.pc   = p;
    e.c    = c;
    exp_q.push_back(e);
  endtask

  // Every instruction IF/ID would load is compared against the next expected entry.
  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!proc_reset && id_valid && id_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_inst: got inst %h pc %h c %0d, none expected", id_inst, id_pc, id_compressed);
        end else begin
          e = exp_q.pop_front();
          if (id_inst !== e.inst || id_pc !== e.pc || id_compressed !== e.c) begin
            errors++;
            $display("FAIL inst_stream: got inst %h pc %h c %0d want inst %h pc %h c %0d",
                     id_inst, id_pc, id_compressed, e.inst, e.pc, e.c);
          end
        end
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem_ok      = '0;
    stall_addr  = '0;
    stall_until = 0;
    exp_q.delete();
  endtask

  task automatic do_reset(input logic rdy);
    proc_reset  = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    id_ready    = rdy;
    @(posedge clk);
    #1 proc_reset = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      #1 n++;
    end
    chk(nm, 32'(exp_q.size()), 32'h0);
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  // Mixed 16/32-bit stream over 6 words; 32-bit instructions at 0x2 and 0xA straddle words.
  task automatic load_stream();
    mem[0] = bsw(32'h0093_0001);
    mem[1] = bsw(32'h4505_0050);
    mem[2] = bsw(32'h0513_4501);
    mem[3] = bsw(32'h0001_00a0);
    mem[4] = bsw(32'h00b0_0593);
    mem[5] = bsw(32'h4601_4581);
    mem_ok[5:0] = 6'h3f;
    expect_inst(32'h0000_0001, 32'h00, 1'b1);
    expect_inst(32'h0050_0093, 32'h02, 1'b0);
    expect_inst(32'h0000_4505, 32'h06, 1'b1);
    expect_inst(32'h0000_4501, 32'h08, 1'b1);
    expect_inst(32'h00a0_0513, 32'h0a, 1'b0);
    expect_inst(32'h0000_0001, 32'h0e, 1'b1);
    expect_inst(32'h00b0_0593, 32'h10, 1'b0);
    expect_inst(32'h0000_4581, 32'h14, 1'b1);
    expect_inst(32'h0000_4601, 32'h16, 1'b1);
  endtask

  initial begin
    proc_reset  = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    id_ready    = 1'b0;
    clear_mem();
    fork
      monitor_loop();
    join_none

    // Reset state and single aligned 32-bit instruction
    clear_mem();
    mem[0] = 32'h9300_5000;
    mem_ok[0] = 1'b1;
    expect_inst(32'h0050_0093, 32'h0, 1'b0);
    do_reset(1'b1);
    chk("rst_valid", 32'(id_valid), 32'h0);
    chk("rst_ren", 32'(icache_ren), 32'h1);
    chk("rst_addr", 32'(icache_addr), 32'h0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_inst", id_inst, 32'h0);
    chk("rst_c", 32'(id_compressed), 32'h0);
    @(negedge clk);
    chk("t1_before_accept", 32'(id_valid), 32'h0);
    @(negedge clk);
    chk("t1_after_accept", 32'(id_valid), 32'h1);
    drain("t1_drain");
    chk("t1_next_pc", id_pc, 32'h4);

    // Straddling instruction waits while the second word stalls 5 cycles
    clear_mem();
    mem[0] = bsw(32'h0093_4505);
    mem[1] = bsw(32'hFFFF_0050);
    mem_ok[1:0] = 2'b11;
    stall_addr = 30'd1;
    expect_inst(32'h0000_4505, 32'h0, 1'b1);
    expect_inst(32'h0050_0093, 32'h2, 1'b0);
    do_reset(1'b1);
    stall_until = cyc + 6;
    @(negedge clk);
    @(negedge clk);
    chk("t2_first_c", 32'(id_compressed), 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_wait_valid", 32'(id_valid), 32'h0);
    end
    @(negedge clk);
    chk("t2_straddle_valid", 32'(id_valid), 32'h1);
    chk("t2_straddle_pc", id_pc, 32'h2);
    drain("t2_drain");

    // Redirect to 0x102 with 4 parcels queued
    clear_mem();
    mem[0] = bsw(32'h0093_0001);
    mem[1] = bsw(32'h4505_0050);
    mem_ok[1:0] = 2'b11;
    mem[8'h40] = bsw(32'h4585_1234);
    mem[8'h41] = bsw(32'h0001_4501);
    mem_ok[8'h40] = 1'b1;
    mem_ok[8'h41] = 1'b1;
    expect_inst(32'h0000_4585, 32'h102, 1'b1);
    expect_inst(32'h0000_4501, 32'h104, 1'b1);
    expect_inst(32'h0000_0001, 32'h106, 1'b1);
    do_reset(1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 redirect = 1'b1;
    redirect_pc = 32'h0000_0102;
    #1;
    chk("t3_redir_valid", 32'(id_valid), 32'h0);
    chk("t3_redir_ren", 32'(icache_ren), 32'h0);
    @(posedge clk);
    #1 redirect = 1'b0;
    id_ready = 1'b1;
    #1;
    chk("t3_addr", 32'(icache_addr), 32'h40);
    chk("t3_pc", id_pc, 32'h102);
    chk("t3_valid_flushed", 32'(id_valid), 32'h0);
    drain("t3_drain");

    // Back-pressure: queue fills, fetch stops, stream continuous on release
    clear_mem();
    load_stream();
    do_reset(1'b0);
    repeat (13) @(negedge clk);
    chk("t4_ren_full", 32'(icache_ren), 32'h0);
    chk("t4_addr_full", 32'(icache_addr), 32'h3);
    chk("t4_valid_full", 32'(id_valid), 32'h1);
    chk("t4_inst_full", id_inst, 32'h1);
    @(posedge clk);
    #1 id_ready = 1'b1;
    drain("t4_drain");

    // Same-cycle push and pop at count = PARCELS-2 with compressed head
    clear_mem();
    load_stream();
    do_reset(1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 id_ready = 1'b1;
    #1;
    chk("t5_ren_at_4", 32'(icache_ren), 32'h1);
    chk("t5_head_c", 32'(id_compressed), 32'h1);
    @(posedge clk);
    #1;
    chk("t5_ren_at_5", 32'(icache_ren), 32'h0);
    chk("t5_addr", 32'(icache_addr), 32'h3);
    drain("t5_drain");

    // proc_reset mid-straddle while the cache stalls
    clear_mem();
    mem[0] = bsw(32'h0093_4505);
    mem[1] = bsw(32'hFFFF_0050);
    mem_ok[1:0] = 2'b11;
    stall_addr = 30'd1;
    expect_inst(32'h0000_4505, 32'h0, 1'b1);
    do_reset(1'b1);
    stall_until = cyc + 100;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("t6_waiting", 32'(id_valid), 32'h0);
    proc_reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_valid", 32'(id_valid), 32'h0);
    chk("t6_addr", 32'(icache_addr), 32'h0);
    chk("t6_pc", id_pc, 32'h0);
    chk("t6_ren", 32'(icache_ren), 32'h1);
    stall_until = 0;
    expect_inst(32'h0000_4505, 32'h0, 1'b1);
    expect_inst(32'h0050_0093, 32'h2, 1'b0);
    proc_reset = 1'b0;
    drain("t6_drain");

    // Redirect with bit0 set to the top of memory; address and PC wrap
    clear_mem();
    mem[255] = bsw(32'h4505_1234);
    mem[0]   = bsw(32'h0001_0001);
    mem_ok[255] = 1'b1;
    mem_ok[0]   = 1'b1;
    expect_inst(32'h0000_4505, 32'hFFFF_FFFE, 1'b1);
    expect_inst(32'h0000_0001, 32'h0, 1'b1);
    expect_inst(32'h0000_0001, 32'h2, 1'b1);
    do_reset(1'b0);
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 redirect = 1'b0;
    id_ready = 1'b1;
    #1;
    chk("t7_addr", 32'(icache_addr), 32'h3FFF_FFFF);
    chk("t7_pc", id_pc, 32'hFFFF_FFFE);
    drain("t7_drain");
    chk("t7_pc_wrapped", id_pc, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
